rat_muldiv: RTL and testbench

- Multi-cycle multiply/divide unit for the RAT CPU, directly downstream of the register file.
- Consumes the register file's DX_OUT/DY_OUT operands; its RESULT is muxed back to register file DIN, with the write strobed by the control unit on DONE.
- Gives the RAT MUL/DIV instructions without adding a combinational 8x8 multiplier or divider to the single-cycle ALU path.

---
 rtl/rat_muldiv_pkg.sv | 23 ++
 rtl/rat_muldiv_dp.sv | 66 ++++++
 rtl/rat_muldiv.sv | 156 +++++++++++++++
 tb/tb_rat_muldiv.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_muldiv_pkg.sv
// Shared types and constants for the RAT multi-cycle multiply/divide unit.
package rat_muldiv_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_MUL_LO = 2'b00,
    OP_MUL_HI = 2'b01,
    OP_DIV_Q  = 2'b10,
    OP_DIV_R  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

  function automatic logic op_is_div(input op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/rat_muldiv_dp.sv
// Shared shift/accumulate datapath: shift-add multiply or restoring divide,
// one bit per step. hi_q is the product high half / partial remainder.
module rat_muldiv_dp
  import rat_muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_next_o,
  output logic [WIDTH-1:0] lo_next_o
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q;
  logic             div_mode_q;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_q};
    fits    = (shifted >= {1'b0, opnd_q});
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (div_mode_q) begin
      // A zero divisor always "fits", yielding all-ones quotient and rem = dividend.
      hi_d = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], fits};
    end else begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign hi_next_o = hi_d;
  assign lo_next_o = lo_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      div_mode_q <= 1'b0;
    end else if (load_i) begin
      hi_q       <= '0;
      lo_q       <= is_div_i ? a_i : b_i;
      opnd_q     <= is_div_i ? b_i : a_i;
      div_mode_q <= is_div_i;
    end else if (step_i) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/rat_muldiv.sv
// RAT MUL/DIV unit: FSM, iteration counter and registered result/flags.
// Define RAT_MULDIV_ZERO_SKIP_EN to finish trivial operands in one cycle.
module rat_muldiv
  import rat_muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] DX_IN,
  input  logic [WIDTH-1:0] DY_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             C_OUT,
  output logic             Z_OUT
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  op_t              op_q;
  logic             div0_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             c_q;
  logic             z_q;

  op_t              op_in;
  logic             load;
  logic             step;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic [WIDTH-1:0] fin_result;
  logic             fin_c;
  logic             skip_take;
  logic [WIDTH-1:0] skip_result;
  logic             skip_c;

  assign op_in = op_t'(OP);
  assign load  = (state_q == ST_IDLE) && START;
  assign step  = (state_q == ST_RUN);

  rat_muldiv_dp #(.WIDTH(WIDTH)) u_dp (
    .clk_i     (CLK),
    .rst_i     (RST),
    .load_i    (load),
    .step_i    (step),
    .is_div_i  (op_is_div(op_in)),
    .a_i       (DX_IN),
    .b_i       (DY_IN),
    .hi_next_o (hi_next),
    .lo_next_o (lo_next)
  );

  // Final-step values are taken straight from the datapath's next state.
  always_comb begin
    fin_result = lo_next;
    fin_c      = 1'b0;
    case (op_q)
      OP_MUL_LO: begin fin_result = lo_next; fin_c = |hi_next; end
      OP_MUL_HI: begin fin_result = hi_next; fin_c = |hi_next; end
      OP_DIV_Q:  begin fin_result = lo_next; fin_c = div0_q;   end
      OP_DIV_R:  begin fin_result = hi_next; fin_c = div0_q;   end
      default:   begin fin_result = lo_next; fin_c = 1'b0;     end
    endcase
  end

`ifdef RAT_MULDIV_ZERO_SKIP_EN
  always_comb begin
    skip_take   = 1'b0;
    skip_result = '0;
    skip_c      = 1'b0;
    if (op_is_div(op_in)) begin
      skip_take   = (DY_IN == '0);
      skip_result = (op_in == OP_DIV_Q) ? {WIDTH{1'b1}} : DX_IN;
      skip_c      = 1'b1;
    end else begin
      skip_take   = (DX_IN == '0) || (DY_IN == '0);
    end
  end
`else
  always_comb begin
    skip_take   = 1'b0;
    skip_result = '0;
    skip_c      = 1'b0;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL_LO;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (START) begin
            op_q   <= op_in;
            div0_q <= (DY_IN == '0);
            cnt_q  <= CW'(WIDTH - 1);
            if (skip_take) begin
              state_q  <= ST_FIN;
              done_q   <= 1'b1;
              result_q <= skip_result;
              c_q      <= skip_c;
              z_q      <= (skip_result == '0);
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (cnt_q == '0) begin
            state_q  <= ST_FIN;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= fin_result;
            c_q      <= fin_c;
            z_q      <= (fin_result == '0);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;
  assign C_OUT  = c_q;
  assign Z_OUT  = z_q;

endmodule

// File: tb/tb_rat_muldiv.sv
// Scoreboard bench for rat_muldiv: stimulus pushes expectations, a negedge
// monitor pops and checks on every DONE pulse.
module tb_rat_muldiv;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [1:0]   OP;
  logic [W-1:0] DX;
  logic [W-1:0] DY;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] RESULT;
  logic         C_OUT;
  logic         Z_OUT;

  rat_muldiv #(.WIDTH(W)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .OP     (OP),
    .DX_IN  (DX),
    .DY_IN  (DY),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT),
    .C_OUT  (C_OUT),
    .Z_OUT  (Z_OUT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int           tag;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    int           cyc;
    int           busy;
  } exp_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] dx;
    logic [W-1:0] dy;
    logic [W-1:0] res;
    logic         c;
    logic         z;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   busy_cnt = 0;
  int   tag_n    = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: one line per completed transaction.
  always @(negedge CLK) begin
    if (RST) begin
      busy_cnt = 0;
    end else begin
      if (BUSY) busy_cnt++;
      if (DONE) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          $display("txn %0d: result=%02h c=%0b z=%0b cyc=%0d busy=%0d",
                   mon_e.tag, RESULT, C_OUT, Z_OUT, cyc, busy_cnt);
          chk($sformatf("t%0d_result", mon_e.tag), int'(RESULT), int'(mon_e.res));
          chk($sformatf("t%0d_c_out", mon_e.tag), int'(C_OUT), int'(mon_e.c));
          chk($sformatf("t%0d_z_out", mon_e.tag), int'(Z_OUT), int'(mon_e.z));
          chk($sformatf("t%0d_done_cycle", mon_e.tag), cyc, mon_e.cyc);
          chk($sformatf("t%0d_busy_cycles", mon_e.tag), busy_cnt, mon_e.busy);
        end
        busy_cnt = 0;
      end
    end
  end

  function automatic bit skip_eligible(input logic [1:0] op, input logic [W-1:0] dx,
                                       input logic [W-1:0] dy);
`ifdef RAT_MULDIV_ZERO_SKIP_EN
    return op[1] ? (dy == '0) : ((dx == '0) || (dy == '0));
`else
    return 1'b0;
`endif
  endfunction

  // Called at a negedge with the DUT idle; capture happens at the next posedge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] dx, input logic [W-1:0] dy,
                       input logic [W-1:0] res, input logic c, input logic z, input bit push);
    exp_t e;
    bit   sk;
    sk     = skip_eligible(op, dx, dy);
    OP     = op;
    DX     = dx;
    DY     = dy;
    START  = 1'b1;
    e.tag  = tag_n;
    e.res  = res;
    e.c    = c;
    e.z    = z;
    e.cyc  = cyc + 1 + (sk ? 0 : W);
    e.busy = sk ? 0 : W;
    if (push) begin
      sb.push_back(e);
      tag_n++;
    end
    @(negedge CLK);
    START = 1'b0;
    OP    = 2'($urandom);
    DX    = W'($urandom);
    DY    = W'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge CLK);
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{2'b00, 8'h0C, 8'h0B, 8'h84, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
    vecs[2]  = '{2'b00, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[3]  = '{2'b10, 8'h64, 8'h07, 8'h0E, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 8'h64, 8'h07, 8'h02, 1'b0, 1'b0};
    vecs[5]  = '{2'b11, 8'h06, 8'h03, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{2'b10, 8'h2A, 8'h00, 8'hFF, 1'b1, 1'b0};
    vecs[7]  = '{2'b11, 8'h2A, 8'h00, 8'h2A, 1'b1, 1'b0};
    vecs[8]  = '{2'b00, 8'h00, 8'h37, 8'h00, 1'b0, 1'b1};
    vecs[9]  = '{2'b01, 8'h37, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{2'b01, 8'h80, 8'h03, 8'h01, 1'b1, 1'b0};
    vecs[11] = '{2'b00, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1};
    vecs[12] = '{2'b10, 8'hFF, 8'h01, 8'hFF, 1'b0, 1'b0};
    vecs[13] = '{2'b11, 8'h05, 8'h09, 8'h05, 1'b0, 1'b0};
    vecs[14] = '{2'b10, 8'h05, 8'h09, 8'h00, 1'b0, 1'b1};

    // Reset with START held high: reset must win.
    RST   = 1'b1;
    START = 1'b1;
    OP    = 2'b00;
    DX    = 8'h12;
    DY    = 8'h34;
    repeat (3) @(negedge CLK);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_result", int'(RESULT), 0);
    chk("rst_c", int'(C_OUT), 0);
    chk("rst_z", int'(Z_OUT), 0);
    RST   = 1'b0;
    START = 1'b0;
    @(negedge CLK);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].dx, vecs[i].dy, vecs[i].res, vecs[i].c, vecs[i].z, 1'b1);
      drain();
    end

    // START while busy must not disturb the latched operands.
    issue(2'b00, 8'h0D, 8'h05, 8'h41, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge CLK);
    START = 1'b1;
    OP    = 2'b10;
    DX    = 8'h01;
    DY    = 8'h01;
    @(negedge CLK);
    START = 1'b0;
    drain();

    // START held through FIN: second capture lands two edges after DONE.
    begin
      exp_t e;
      int   n;
      n      = cyc;
      OP     = 2'b00;
      DX     = 8'h0C;
      DY     = 8'h0B;
      START  = 1'b1;
      e.res  = 8'h84;
      e.c    = 1'b0;
      e.z    = 1'b0;
      e.busy = W;
      e.tag  = tag_n++;
      e.cyc  = n + 1 + W;
      sb.push_back(e);
      e.tag  = tag_n++;
      e.cyc  = n + 2 * W + 3;
      sb.push_back(e);
      repeat (W + 3) @(negedge CLK);
      START = 1'b0;
      drain();
    end

    // Abort mid-operation: no DONE, outputs cleared on the reset edge.
    issue(2'b01, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_done", int'(DONE), 0);
    chk("abort_result", int'(RESULT), 0);
    chk("abort_c", int'(C_OUT), 0);
    chk("abort_z", int'(Z_OUT), 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (15) @(negedge CLK);
    chk("abort_idle_busy", int'(BUSY), 0);
    issue(2'b10, 8'h64, 8'h07, 8'h0E, 1'b0, 1'b0, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
